// File: rtl/control_unit.sv
// Purpose: microsequencer for the 8-bit shared-bus datapath; decodes step/opcode/flags into bus strobes.
// Latency: strobes are combinational from the current microstep; the step counter advances every clock.
// Backpressure: none; one microstep per clock until HLT, then frozen until reset.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_carry,
    input  logic       flag_zero,
    output logic       pc_oe,
    output logic       ir_oe,
    output logic       ram_oe,
    output logic       a_oe,
    output logic       alu_oe,
    output logic       mar_load,
    output logic       ir_load,
    output logic       a_load,
    output logic       b_load,
    output logic       out_load,
    output logic       ram_we,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       alu_sub,
    output logic       flags_load,
    output logic [2:0] step,
    output logic       halted
);

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    logic [2:0] step_q;
    logic [2:0] step_d;
    logic       halted_q;
    logic       halted_d;
    logic       last_step;

    // State register: microstep counter and halted flag, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Next state: wrap to T0 after each instruction's final step; illegal counts recover to T0.
    always_comb begin
        last_step = 1'b0;
        if (step_q >= T2) begin
            case (opcode)
                OP_LDA, OP_STA: last_step = (step_q >= T3);
                OP_ADD, OP_SUB: last_step = (step_q >= T4);
                default:        last_step = 1'b1;
            endcase
        end

        step_d   = step_q + 3'd1;
        halted_d = halted_q;
        if (halted_q || step_q > T4 || last_step) begin
            step_d = T0;
        end
        if (!halted_q && step_q == T2 && opcode == OP_HLT) begin
            halted_d = 1'b1;
        end
    end

    // Output decode: strobes for the current microstep; everything quiet when halted or illegal.
    always_comb begin
        pc_oe      = 1'b0;
        ir_oe      = 1'b0;
        ram_oe     = 1'b0;
        a_oe       = 1'b0;
        alu_oe     = 1'b0;
        mar_load   = 1'b0;
        ir_load    = 1'b0;
        a_load     = 1'b0;
        b_load     = 1'b0;
        out_load   = 1'b0;
        ram_we     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_sub    = 1'b0;
        flags_load = 1'b0;
        if (!halted_q) begin
            case (step_q)
                T0: begin
                    pc_oe    = 1'b1;
                    mar_load = 1'b1;
                end
                T1: begin
                    ram_oe  = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_oe    = 1'b1;
                            mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            ir_oe  = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe   = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ir_oe   = flag_carry;
                            pc_load = flag_carry;
                        end
                        OP_JZ: begin
                            ir_oe   = flag_zero;
                            pc_load = flag_zero;
                        end
                        OP_OUT: begin
                            a_oe     = 1'b1;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_load = 1'b1;
                        end
                        OP_STA: begin
                            a_oe   = 1'b1;
                            ram_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe     = 1'b1;
                        a_load     = 1'b1;
                        flags_load = 1'b1;
                        alu_sub    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Purpose: runs small programs through a behavioural datapath driven by control_unit strobes.
// Latency: checks sampled on the falling edge, half a cycle after each rising edge.
// Backpressure: none; expected OUT values queued at program load, popped on each out_load.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       flag_carry, flag_zero;
    logic       pc_oe, ir_oe, ram_oe, a_oe, alu_oe;
    logic       mar_load, ir_load, a_load, b_load, out_load, ram_we;
    logic       pc_inc, pc_load, alu_sub, flags_load;
    logic [2:0] step;
    logic       halted;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .flag_carry(flag_carry), .flag_zero(flag_zero),
        .pc_oe(pc_oe), .ir_oe(ir_oe), .ram_oe(ram_oe), .a_oe(a_oe), .alu_oe(alu_oe),
        .mar_load(mar_load), .ir_load(ir_load), .a_load(a_load), .b_load(b_load),
        .out_load(out_load), .ram_we(ram_we), .pc_inc(pc_inc), .pc_load(pc_load),
        .alu_sub(alu_sub), .flags_load(flags_load), .step(step), .halted(halted)
    );

    always #5 clk = ~clk;

    // Strobe vector, bit 14 down to 0.
    logic [14:0] strobes;
    assign strobes = {pc_oe, ir_oe, ram_oe, a_oe, alu_oe, mar_load, ir_load, a_load,
                      b_load, out_load, ram_we, pc_inc, pc_load, alu_sub, flags_load};

    localparam logic [14:0] S_T0      = 15'b100001000000000;
    localparam logic [14:0] S_ADD_T3  = 15'b001000001000000;
    localparam logic [14:0] S_ADD_T4  = 15'b000010010000001;
    localparam logic [14:0] S_SUB_T4  = 15'b000010010000011;
    localparam logic [14:0] S_JZ_TAKE = 15'b010000000000100;
    localparam logic [14:0] S_STA_T3  = 15'b000100000010000;

    // Behavioural datapath.
    logic [7:0] prog [16];
    logic [7:0] ram  [16];
    logic [7:0] a_reg, b_reg, ir_reg, out_reg, bus;
    logic [3:0] pc_reg, mar_reg;
    logic [8:0] alu9;
    logic       carry_reg, zero_reg;

    assign opcode     = ir_reg[7:4];
    assign flag_carry = carry_reg;
    assign flag_zero  = zero_reg;
    assign alu9 = alu_sub ? ({1'b0, a_reg} + {1'b0, ~b_reg} + 9'd1)
                          : ({1'b0, a_reg} + {1'b0, b_reg});

    always_comb begin
        bus = 8'h00;
        if (pc_oe)  bus = {4'h0, pc_reg};
        if (ir_oe)  bus = {4'h0, ir_reg[3:0]};
        if (ram_oe) bus = ram[mar_reg];
        if (a_oe)   bus = a_reg;
        if (alu_oe) bus = alu9[7:0];
    end

    always @(posedge clk) begin
        if (reset) begin
            ram <= prog;
            pc_reg <= 4'h0; mar_reg <= 4'h0; a_reg <= 8'h00; b_reg <= 8'h00;
            ir_reg <= 8'h00; out_reg <= 8'h00; carry_reg <= 1'b0; zero_reg <= 1'b0;
        end else begin
            if (mar_load) mar_reg <= bus[3:0];
            if (ir_load)  ir_reg  <= bus;
            if (a_load)   a_reg   <= bus;
            if (b_load)   b_reg   <= bus;
            if (out_load) out_reg <= bus;
            if (ram_we)   ram[mar_reg] <= bus;
            if (pc_load)       pc_reg <= bus[3:0];
            else if (pc_inc)   pc_reg <= pc_reg + 4'd1;
            if (flags_load) begin
                carry_reg <= alu9[8];
                zero_reg  <= (alu9[7:0] == 8'h00);
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every-cycle monitor: single bus driver, quiet when halted, scoreboard on out_load.
    always @(negedge clk) begin
        if (!reset) begin
            check("oe_single", 16'($countones({pc_oe, ir_oe, ram_oe, a_oe, alu_oe}) <= 1), 16'd1);
            if (halted) begin
                check("halted_quiet", 16'(strobes), 16'd0);
                check("halted_step", 16'(step), 16'd0);
            end
            if (ram_we) begin
                we_cnt++;
                check("ram_we_step", 16'(step), 16'd3);
            end
            if (out_load) begin
                if (exp_q.size() == 0) check("out_unexpected", 16'(bus), 16'hFFFF);
                else check("out_value", 16'(bus), 16'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (!halted && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halt"}, 16'(halted), 16'd1);
        check({tag, "_queue_empty"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        int we_before;
        reset = 1'b1;
        clear_prog();

        // LDI 7, OUT, HLT
        prog[0] = 8'h57; prog[1] = 8'hE0; prog[2] = 8'hF0;
        exp_q.push_back(8'h07);
        do_reset();
        check("rst_step", 16'(step), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_strobes", 16'(strobes), 16'(S_T0));
        cycles(6);
        check("t1_out_reg", 16'(out_reg), 16'h07);
        check("t1_not_halted", 16'(halted), 16'd0);
        cycles(3);
        check("t1_halted", 16'(halted), 16'd1);
        check("t1_quiet", 16'(strobes), 16'd0);
        cycles(4);
        check("t1_still_quiet", 16'(strobes), 16'd0);
        check("t1_queue_empty", 16'(exp_q.size()), 16'd0);

        // LDA 14, ADD 15, OUT, HLT: 5 + 0xFC = 0x101
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'h05; prog[15] = 8'hFC;
        exp_q.push_back(8'h01);
        do_reset();
        cycles(4);
        check("t2_add_t0", 16'(step), 16'd0);
        cycles(3);
        check("t2_add_t3", 16'(strobes), 16'(S_ADD_T3));
        cycles(1);
        check("t2_add_t4_step", 16'(step), 16'd4);
        check("t2_add_t4", 16'(strobes), 16'(S_ADD_T4));
        cycles(1);
        check("t2_add_len", 16'(step), 16'd0);
        check("t2_carry", 16'(flag_carry), 16'd1);
        check("t2_zero", 16'(flag_zero), 16'd0);
        run_to_halt("t2");

        // LDI 9, SUB 15, JZ 6 with equal and unequal operands
        for (int k = 0; k < 2; k++) begin
            clear_prog();
            prog[0] = 8'h59; prog[1] = 8'h3F; prog[2] = 8'h86;
            prog[3] = 8'h51; prog[4] = 8'hE0; prog[5] = 8'hF0;
            prog[6] = 8'hE0; prog[7] = 8'hF0;
            prog[15] = (k == 0) ? 8'h09 : 8'h08;
            exp_q.push_back((k == 0) ? 8'h00 : 8'h01);
            do_reset();
            cycles(7);
            check("t3_sub_t4", 16'(strobes), 16'(S_SUB_T4));
            cycles(3);
            check("t3_jz_step", 16'(step), 16'd2);
            check("t3_jz_strobes", 16'(strobes), (k == 0) ? 16'(S_JZ_TAKE) : 16'd0);
            cycles(1);
            check("t3_fetch_addr", 16'(bus), (k == 0) ? 16'd6 : 16'd3);
            run_to_halt("t3");
        end

        // LDA 12 (0xA5), STA 13, LDI 0, LDA 13, OUT, HLT
        clear_prog();
        prog[0] = 8'h1C; prog[1] = 8'h4D; prog[2] = 8'h50; prog[3] = 8'h1D;
        prog[4] = 8'hE0; prog[5] = 8'hF0; prog[12] = 8'hA5;
        exp_q.push_back(8'hA5);
        we_before = we_cnt;
        do_reset();
        cycles(7);
        check("t4_sta_t3", 16'(strobes), 16'(S_STA_T3));
        run_to_halt("t4");
        check("t4_we_count", 16'(we_cnt - we_before), 16'd1);
        check("t4_ram13", 16'(ram[13]), 16'hA5);

        // LDI 3, undefined 0xB, LDI 4, OUT, HLT
        clear_prog();
        prog[0] = 8'h53; prog[1] = 8'hB0; prog[2] = 8'h54; prog[3] = 8'hE0; prog[4] = 8'hF0;
        exp_q.push_back(8'h04);
        do_reset();
        cycles(5);
        check("t5_undef_step", 16'(step), 16'd2);
        check("t5_undef_quiet", 16'(strobes), 16'd0);
        cycles(1);
        check("t5_undef_len", 16'(step), 16'd0);
        run_to_halt("t5");

        // Reset during ADD T3, then rerun from the start
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'h05; prog[15] = 8'hFC;
        exp_q.push_back(8'h01);
        do_reset();
        cycles(7);
        check("t6_add_t3", 16'(strobes), 16'(S_ADD_T3));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_abort_step", 16'(step), 16'd0);
        check("t6_abort_strobes", 16'(strobes), 16'(S_T0));
        check("t6_abort_halted", 16'(halted), 16'd0);
        run_to_halt("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microsequencer for the 8-bit shared-bus datapath: A, B, IR, PC, MAR, RAM, ALU and the output register.
- Holds a microstep counter and decodes the IR opcode plus the ALU flags.
- Drives every bus-enable and register-load strobe, one microstep per clock.
- Runs the fetch/execute loop until HLT.

Parameters:
- None. Opcode width is fixed at 4 bits and the step counter at 3 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears step counter and halted flag
- opcode  in  4  IR[7:4], valid from the cycle after ir_load
- flag_carry  in  1  registered ALU carry flag
- flag_zero  in  1  registered ALU zero flag
- pc_oe  out  1  PC drives bus
- ir_oe  out  1  IR operand nibble drives bus (zero-extended)
- ram_oe  out  1  RAM[MAR] drives bus
- a_oe  out  1  A drives bus
- alu_oe  out  1  ALU result drives bus
- mar_load  out  1  MAR <= bus[3:0]
- ir_load  out  1  IR <= bus
- a_load  out  1  A <= bus
- b_load  out  1  B <= bus
- out_load  out  1  output register <= bus
- ram_we  out  1  RAM[MAR] <= bus
- pc_inc  out  1  PC <= PC+1 (wraps 15->0)
- pc_load  out  1  PC <= bus[3:0]
- alu_sub  out  1  ALU computes A-B (two's complement), else A+B
- flags_load  out  1  ALU flag registers capture
- step  out  3  current microstep T0..T4, for debug
- halted  out  1  high once HLT has executed

Behaviour:
- Control outputs are a pure decode of (step, opcode, flags, halted). Strobes asserted during step Tn take effect at the rising edge that ends Tn.
- Reset: step=0, halted=0. Each strobe is 0 unless its decode for T0 under reset state says otherwise (T0 asserts pc_oe and mar_load).
- At most one *_oe is high in any cycle. The bench asserts this invariant every cycle.
- Fetch (every instruction):
  - T0: pc_oe, mar_load
  - T1: ram_oe, ir_load, pc_inc
- Execute, keyed on opcode sampled during T2 onwards:
  - 0x0 NOP: T2 no strobes; end
  - 0x1 LDA: T2 ir_oe, mar_load; T3 ram_oe, a_load; end
  - 0x2 ADD: T2 ir_oe, mar_load; T3 ram_oe, b_load; T4 alu_oe, a_load, flags_load; end
  - 0x3 SUB: as ADD, with alu_sub=1 in T4 only
  - 0x4 STA: T2 ir_oe, mar_load; T3 a_oe, ram_we; end
  - 0x5 LDI: T2 ir_oe, a_load; end
  - 0x6 JMP: T2 ir_oe, pc_load; end
  - 0x7 JC: T2 ir_oe, pc_load only if flag_carry=1, else no strobes; end
  - 0x8 JZ: T2 as JC, gated by flag_zero
  - 0xE OUT: T2 a_oe, out_load; end
  - 0xF HLT: T2 no strobes; halted<=1 at end of T2
  - 0x9-0xD: undefined, executed as NOP
- "end": step returns to 0 on the edge closing the final step; no idle cycles between instructions. Otherwise step increments.
- Instruction lengths: NOP, LDI, JMP, JC, JZ, OUT = 3 cycles; LDA, STA = 4 cycles; ADD, SUB = 5 cycles. HLT = 3 cycles, then halted.
- Halted: all strobes 0 and step frozen at 0 until reset. halted is cleared only by reset.
- Flags are sampled combinationally in T2. A JC/JZ immediately after ADD/SUB sees the flags captured in that instruction's T4.
- Reset mid-instruction: next edge forces step=0 and halted=0. Any partial instruction is abandoned with no further strobes.
- step never exceeds 4. Any illegal counter value returns to 0 on the next edge with all strobes 0.

Test Plan:
- Reset, then LDI 7 (0x57), OUT (0xE0), HLT (0xF0) in RAM[0..2] -> out register=0x07 after cycle 6; halted=1 after cycle 9; strobes all 0 thereafter.
- LDA 14 with RAM[14]=0x05, ADD 15 with RAM[15]=0xFC, OUT -> output 0x01; flag_carry=1 and flag_zero=0 after ADD T4; ADD occupies exactly 5 cycles.
- SUB equal operands (A=0x09, RAM[15]=0x09), then JZ 6 -> pc_load asserted in JZ T2, next fetch at address 6. Repeat with RAM[15]=0x08 -> no pc_load, fetch continues at the next sequential address.
- STA 13 with A=0xA5, then LDA 13, OUT -> ram_we in STA T3 only; output 0xA5.
- Undefined opcode 0xB between two LDIs -> 3-cycle NOP, no strobes in T2, following LDI executes normally.
- Reset asserted during ADD T3 -> next cycle step=0 with pc_oe and mar_load; no a_load/flags_load from the aborted ADD. Single-driver assertion holds throughout.
